// File: rtl/dram_req_ctrl_pkg.sv
// dram_req_ctrl_pkg: shared types and default geometry for the DRAM request controller
//   state_t  controller phase: CLEAR (zero-fill after reset) or RUN (serving requests)
//   req_t    one request at default geometry: write flag, word address, write data
package dram_req_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_RSP_DEPTH  = 4;
    typedef enum logic {CLEAR, RUN} state_t;
    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } req_t;
endpackage

// File: rtl/dram_rsp_fifo.sv
// dram_rsp_fifo: first-word-fall-through response queue for read data
//   clk, rst_n   clock, synchronous active-low reset (empties the queue)
//   push, din    write din at the tail
//   pop, dout    dout is the head entry; pop retires it
//   full, empty  occupancy flags
//   count        number of stored entries (0..RSP_DEPTH)
module dram_rsp_fifo
    import dram_req_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(RSP_DEPTH):0]   count
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(RSP_DEPTH));

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= (push && !pop) ? count + CW'(1) :
                      (pop && !push) ? count - CW'(1) : count;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/dram_req_ctrl.sv
// dram_req_ctrl: valid/ready front end for a simple dual-port DRAM block with credit-protected read responses
//   clk, rst_n                 single clock (also the memory's clka), synchronous active-low reset
//   req_valid/ready/we/addr/wdata   request stream; one read or write per accepted beat
//   rsp_valid/ready/rdata      read data returned in request order
//   init_done                  memory zero-fill finished (or skipped), requests may be accepted
//   mem_ena/wea/addra/dina     registered port A write strobes
//   mem_enb/addrb              registered port B read strobes
//   mem_doutb                  port B read data, valid the cycle after mem_enb
module dram_req_ctrl
    import dram_req_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH      = DEF_RSP_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  mem_ena,
    output logic                  mem_wea,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dina,
    output logic                  mem_enb,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_doutb
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    state_t                state;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] clr_addr_d;
    logic                  ena_d;
    logic                  enb_d;
    logic [ADDR_WIDTH-1:0] addra_d;
    logic [ADDR_WIDTH-1:0] addrb_d;
    logic [DATA_WIDTH-1:0] dina_d;
    logic                  rd_pend;
    logic                  accept;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         used;

    // credits: queued responses plus reads still travelling through the memory
    // (mem_enb = issued this cycle, rd_pend = data on mem_doutb awaiting capture);
    // a same-cycle pop is deliberately not credited
    assign used      = fifo_count + CW'(mem_enb) + CW'(rd_pend);
    assign req_ready = (state == RUN) && !fifo_full && (used < CW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign init_done = (state == RUN);
    assign mem_wea   = mem_ena;
    assign rsp_valid = !fifo_empty;

    always_comb begin
        state_d    = state;
        clr_addr_d = clr_addr;
        ena_d      = 1'b0;
        enb_d      = 1'b0;
        addra_d    = mem_addra;
        dina_d     = mem_dina;
        addrb_d    = mem_addrb;
        if (state == CLEAR) begin
            // with clearing disabled CLEAR lasts a single strobe-free cycle
            state_d    = (CLEAR_ON_RESET == 0 || clr_addr == '1) ? RUN : CLEAR;
            ena_d      = (CLEAR_ON_RESET != 0);
            addra_d    = clr_addr;
            dina_d     = '0;
            clr_addr_d = clr_addr + ADDR_WIDTH'(1);
        end else if (accept) begin
            ena_d   = req_we;
            enb_d   = !req_we;
            addra_d = req_we ? req_addr : mem_addra;
            dina_d  = req_we ? req_wdata : mem_dina;
            addrb_d = req_we ? mem_addrb : req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            mem_ena   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= state_d;
            clr_addr  <= clr_addr_d;
            mem_ena   <= ena_d;
            mem_addra <= addra_d;
            mem_dina  <= dina_d;
            mem_enb   <= enb_d;
            mem_addrb <= addrb_d;
            rd_pend   <= mem_enb;
        end
    end

    dram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend),
        .din   (mem_doutb),
        .pop   (rsp_valid && rsp_ready),
        .dout  (rsp_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_dram_req_ctrl.sv
// tb_dram_req_ctrl: directed self-checking bench for dram_req_ctrl
module tb_dram_req_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready, rsp_valid, init_done;
    logic          mem_ena, mem_wea, mem_enb;
    logic [AW-1:0] mem_addra, mem_addrb;
    logic [DW-1:0] mem_dina, mem_doutb, rsp_rdata;

    logic          u1_req_ready, u1_rsp_valid, u1_init_done;
    logic          u1_ena, u1_wea, u1_enb;
    logic [AW-1:0] u1_addra, u1_addrb;
    logic [DW-1:0] u1_dina, u1_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
    );

    dram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH), .CLEAR_ON_RESET(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(1'b0), .req_ready(u1_req_ready), .req_we(1'b0),
        .req_addr('0), .req_wdata('0),
        .rsp_valid(u1_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(u1_rdata),
        .init_done(u1_init_done),
        .mem_ena(u1_ena), .mem_wea(u1_wea), .mem_addra(u1_addra), .mem_dina(u1_dina),
        .mem_enb(u1_enb), .mem_addrb(u1_addrb), .mem_doutb('0)
    );

    // memory model: locations never written read back as garbage so a missing clear shows up
    logic [DW-1:0]    ram [2**AW];
    logic [2**AW-1:0] wr_mask = '0;
    always @(posedge clk) begin
        if (mem_ena && mem_wea) begin
            ram[mem_addra]     <= mem_dina;
            wr_mask[mem_addra] <= 1'b1;
        end
        if (mem_enb)
            mem_doutb <= wr_mask[mem_addrb] ? ram[mem_addrb] : 32'hDEADBEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: expected read data from a reference copy of memory, checked in order
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] exp_q [$];
    int            outstanding = 0;
    int            u1_wr = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        end else begin
            check("no_stale", {63'b0, rsp_valid && exp_q.size() == 0}, 64'd0);
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                check("rsp_data", {32'b0, rsp_rdata}, {32'b0, exp_q.pop_front()});
                outstanding--;
            end
            if (req_valid && req_ready) begin
                if (req_we)
                    ref_mem[req_addr] = req_wdata;
                else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    outstanding++;
                end
            end
            check("credit_bound", {63'b0, outstanding <= DEPTH}, 64'd1);
            if (u1_ena) u1_wr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear();
        for (int i = 0; i < 2**AW; i++) begin
            tick();
            check("clr_ena", {63'b0, mem_ena && mem_wea}, 64'd1);
            check("clr_addr", {60'b0, mem_addra}, 64'(i));
            check("clr_din", {32'b0, mem_dina}, 64'd0);
            check("clr_done", {63'b0, init_done}, {63'b0, i == 2**AW - 1});
            check("clr_ready", {63'b0, req_ready}, {63'b0, i == 2**AW - 1});
            if (i == 0) begin
                check("u1_done", {63'b0, u1_init_done}, 64'd1);
                check("u1_ready", {63'b0, u1_req_ready}, 64'd1);
            end
        end
        tick();
        check("clr_end", {63'b0, mem_ena}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        repeat (3) tick();
        check("rst_ready", {63'b0, req_ready}, 64'd0);
        check("rst_rspv", {63'b0, rsp_valid}, 64'd0);
        check("rst_done", {63'b0, init_done}, 64'd0);
        check("rst_ena", {63'b0, mem_ena}, 64'd0);
        check("rst_enb", {63'b0, mem_enb}, 64'd0);
        check("rst_addra", {60'b0, mem_addra}, 64'd0);
        check("u1_rst_done", {63'b0, u1_init_done}, 64'd0);
        check("u1_rst_ready", {63'b0, u1_req_ready}, 64'd0);
        rst_n = 1'b1;
        check_clear();

        // write 0xA5 to 3, then read 3 on the very next cycle
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 32'hA5; rsp_ready = 1'b1;
        tick();
        check("wr_ena", {63'b0, mem_ena}, 64'd1);
        check("wr_addr", {60'b0, mem_addra}, 64'd3);
        check("wr_din", {32'b0, mem_dina}, 64'hA5);
        check("wr_no_enb", {63'b0, mem_enb}, 64'd0);
        req_we = 1'b0;
        tick();
        check("rd_enb", {63'b0, mem_enb}, 64'd1);
        check("rd_addrb", {60'b0, mem_addrb}, 64'd3);
        check("rd_no_ena", {63'b0, mem_ena}, 64'd0);
        req_valid = 1'b0;
        tick();
        check("lat_2", {63'b0, rsp_valid}, 64'd0);
        tick();
        check("lat_3", {63'b0, rsp_valid}, 64'd1);
        check("raw_data", {32'b0, rsp_rdata}, 64'hA5);
        tick();
        check("popped", {63'b0, rsp_valid}, 64'd0);
        check("idle_enb", {63'b0, mem_enb}, 64'd0);

        // fill addresses 0..5 with 0x100+addr
        req_valid = 1'b1; req_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = AW'(i); req_wdata = 32'h100 + 32'(i);
            check("wr_ready", {63'b0, req_ready}, 64'd1);
            tick();
        end
        req_valid = 1'b0;
        tick();

        // back-to-back reads with the consumer stalled: only DEPTH accepted
        rsp_ready = 1'b0; req_we = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = AW'(k);
            check("fill_ready", {63'b0, req_ready}, 64'd1);
            tick();
        end
        req_addr = 4'd4;
        check("fill_stall", {63'b0, req_ready}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_ready", {63'b0, req_ready}, 64'd0);
            check("stall_head", {32'b0, rsp_rdata}, 64'h100);
        end

        // one pop while full: credit returns only on the following cycle
        rsp_ready = 1'b1;
        check("pop_no_credit", {63'b0, req_ready}, 64'd0);
        tick();
        rsp_ready = 1'b0;
        check("post_pop_ready", {63'b0, req_ready}, 64'd1);
        check("post_pop_head", {32'b0, rsp_rdata}, 64'h101);
        tick();
        check("r4_stall", {63'b0, req_ready}, 64'd0);
        req_addr = 4'd5;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            acc = req_valid && req_ready;
            tick();
            if (acc) req_valid = 1'b0;
        end
        check("r5_taken", {63'b0, req_valid}, 64'd0);
        check("drain_all", 64'(exp_q.size()), 64'd0);

        // unwritten location reads back the cleared value
        req_valid = 1'b1; req_addr = 4'd9;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("rd9_done", 64'(exp_q.size()), 64'd0);

        // reset with two reads in flight and one queued
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = AW'(k);
            tick();
        end
        req_valid = 1'b0;
        check("pre_rst_valid", {63'b0, rsp_valid}, 64'd1);
        check("pre_rst_enb", {63'b0, mem_enb}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        check("mid_rst_rspv", {63'b0, rsp_valid}, 64'd0);
        check("mid_rst_ready", {63'b0, req_ready}, 64'd0);
        check("mid_rst_done", {63'b0, init_done}, 64'd0);
        check("mid_rst_enb", {63'b0, mem_enb}, 64'd0);
        check_clear();

        // address 3 held 0xA5 before the second clear
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("final_drain", 64'(exp_q.size()), 64'd0);
        check("u1_no_writes", 64'(u1_wr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
